// File: rtl/trng_collector.sv
// trng_collector: resynchronises a ring-oscillator bit, von Neumann debiases it and packs WIDTH-bit words.
// Optional repetition-count health test is built when the TRNG_HEALTH_EN macro is defined.
module trng_collector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int REP_LIMIT   = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             health_fail,
  output logic             dbg_state_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } pair_state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  pair_state_e      state_q, state_d;
  logic             a_q, a_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             emit, load, handshake;
  logic             hf_now, hf_next;

  assign s = sync_q[SYNC_STAGES-1];

  // Free-running resynchroniser; enable never gates it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam logic [7:0] REP_MAX = 8'(REP_LIMIT);

  logic [7:0] rc_q, rc_d;
  logic       prev_q, prev_d;
  logic       hf_q, hf_d;

  always_comb begin
    rc_d   = rc_q;
    prev_d = prev_q;
    hf_d   = hf_q;
    if (enable) begin
      prev_d = s;
      if (s != prev_q) begin
        rc_d = 8'd1;
      end else if (rc_q != REP_MAX) begin
        rc_d = rc_q + 8'd1;
      end
      if (rc_d == REP_MAX) begin
        hf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rc_q   <= 8'd0;
      prev_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      rc_q   <= rc_d;
      prev_q <= prev_d;
      hf_q   <= hf_d;
    end
  end

  assign hf_now  = hf_q;
  assign hf_next = hf_d;
`else
  assign hf_now  = 1'b0;
  assign hf_next = 1'b0;
`endif

  // Output handshake: a word transfers on a rising edge where valid && ready;
  // data is stable while valid is high, and the source is never stalled, so a
  // word completed while the output register is occupied is dropped.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    emit      = 1'b0;
    load      = 1'b0;
    sh_next   = {sh_q[WIDTH-2:0], a_q};
    handshake = valid_q && ready && !hf_now;

    if (!enable) begin
      state_d = FIRST;
      sh_d    = '0;
      cnt_d   = '0;
    end else if (state_q == FIRST) begin
      a_d     = s;
      state_d = SECOND;
    end else begin
      state_d = FIRST;
      emit    = (a_q != s) && !hf_now;
    end

    if (emit) begin
      sh_d = sh_next;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        load  = !valid_q || handshake;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (load) begin
      data_d  = sh_next;
      valid_d = 1'b1;
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    // A failing source must not hand out a word, including one already held.
    if (hf_next) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FIRST;
      a_q     <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign health_fail = hf_now;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: directed and random stimulus checked against a queue-based reference model.
module tb_trng_collector;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int REP_LIMIT   = 32;

  logic             clock;
  logic             reset_n;
  logic             enable;
  logic             raw_bit;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             health_fail;
  logic             dbg_state_o;

  trng_collector #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .REP_LIMIT  (REP_LIMIT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .raw_bit    (raw_bit),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .health_fail(health_fail),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit               pipe[$];
  bit               part[$];
  bit               have_first;
  bit               first_bit;
  logic [WIDTH-1:0] m_data;
  bit               m_valid;
  bit               m_hf;
  bit               m_prev;
  int               run;
  logic [WIDTH-1:0] exp_q[$];
  int               acc_cnt;
  logic [WIDTH-1:0] last_acc;

  // directed schedule: synchronised sample wanted at each edge, and enable
  bit samp_q[$];
  bit en_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    repeat (SYNC_STAGES) pipe.push_back(1'b0);
    part.delete();
    have_first = 1'b0;
    first_bit  = 1'b0;
    m_data     = '0;
    m_valid    = 1'b0;
    m_hf       = 1'b0;
    m_prev     = 1'b0;
    run        = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit en, input bit rw, input bit rdy);
    bit               s_m, hf_old, hs, load;
    logic [WIDTH-1:0] word;
    s_m = pipe.pop_front();
    pipe.push_back(rw);
    hf_old = m_hf;
    hs     = m_valid && rdy && !hf_old;
    load   = 1'b0;
    word   = '0;
`ifdef TRNG_HEALTH_EN
    if (en) begin
      if (s_m == m_prev) run = (run < REP_LIMIT) ? run + 1 : run;
      else run = 1;
      m_prev = s_m;
      if (run >= REP_LIMIT) m_hf = 1'b1;
    end
`endif
    if (!en) begin
      have_first = 1'b0;
      part.delete();
    end else if (!have_first) begin
      have_first = 1'b1;
      first_bit  = s_m;
    end else begin
      have_first = 1'b0;
      if (first_bit != s_m && !hf_old) begin
        part.push_back(first_bit);
        if (part.size() == WIDTH) begin
          foreach (part[i]) word = {word[WIDTH-2:0], part[i]};
          part.delete();
          load = !m_valid || hs;
        end
      end
    end
    if (load) begin
      m_data  = word;
      m_valid = 1'b1;
      exp_q.push_back(word);
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (m_hf) m_valid = 1'b0;
  endtask

  // driver: one clock cycle, inputs applied 1 time unit after the previous edge
  task automatic step(input bit en, input bit rw, input bit rdy);
    enable  = en;
    raw_bit = rw;
    ready   = rdy;
    if (valid === 1'b1 && rdy && health_fail !== 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_data", 32'(data), 32'(exp_q.pop_front()));
      acc_cnt++;
      last_acc = data;
    end
    @(posedge clock);
    model_edge(en, rw, rdy);
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
    chk("pair_state", 32'(dbg_state_o), 32'(have_first));
    if (m_valid) chk("data", 32'(data), 32'(m_data));
  endtask

  task automatic push_pair(input bit a, input bit b);
    samp_q.push_back(a); en_q.push_back(1'b1);
    samp_q.push_back(b); en_q.push_back(1'b1);
  endtask

  task automatic push_gap();
    samp_q.push_back(1'b0); en_q.push_back(1'b0);
  endtask

  task automatic run_sched(input bit rdy);
    int n;
    bit en_j, raw_j;
    n = samp_q.size();
    for (int j = 0; j < n + SYNC_STAGES; j++) begin
      en_j  = (j >= SYNC_STAGES) ? en_q[j-SYNC_STAGES] : 1'b0;
      raw_j = (j < n) ? samp_q[j] : 1'($urandom_range(0, 1));
      step(en_j, raw_j, rdy);
    end
    samp_q.delete();
    en_q.delete();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_valid", 32'(valid), 32'd0);
    chk("rst_async_data", 32'(data), 32'd0);
    chk("rst_async_hf", 32'(health_fail), 32'd0);
    chk("rst_async_state", 32'(dbg_state_o), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  int acc0;

  initial begin
    acc_cnt  = 0;
    last_acc = '0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    ready    = 1'b1;
    raw_bit  = 1'b0;
    model_reset();

    // reset held with random raw_bit and ready=1
    for (int i = 0; i < 6; i++) begin
      raw_bit = 1'($urandom_range(0, 1));
      enable  = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_hf", 32'(health_fail), 32'd0);
    end
    reset_n = 1'b1;
    drain(3);

    // debias and pack: 01,10,10,01,01,01,10,10 -> 0110_0011
    acc0 = acc_cnt;
    push_pair(0, 1); push_pair(1, 0); push_pair(1, 0); push_pair(0, 1);
    push_pair(0, 1); push_pair(0, 1); push_pair(1, 0); push_pair(1, 0);
    run_sched(1'b1);
    chk("pack_valid_rise", 32'(valid), 32'd1);
    chk("pack_data", 32'(data), 32'h63);
    drain(4);
    chk("pack_count", 32'(acc_cnt - acc0), 32'd1);
    chk("pack_accepted", 32'(last_acc), 32'h63);

    // equal pairs discarded: 00,11 interleaved with 01 x8 -> 8'h00
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_pair(0, 0); else push_pair(1, 1);
      push_pair(0, 1);
    end
    run_sched(1'b1);
    drain(4);
    chk("discard_count", 32'(acc_cnt - acc0), 32'd1);
    chk("discard_word", 32'(last_acc), 32'h00);

    // backpressure: three words of 01,10 with ready=0, only the first is kept
    acc0 = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      push_pair(0, 1);
      push_pair(1, 0);
    end
    run_sched(1'b0);
    chk("bp_valid_held", 32'(valid), 32'd1);
    chk("bp_data_held", 32'(data), 32'h55);
    chk("bp_none_taken", 32'(acc_cnt - acc0), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_valid_drop", 32'(valid), 32'd0);
    chk("bp_accepted", 32'(last_acc), 32'h55);
    drain(4);
    chk("bp_count", 32'(acc_cnt - acc0), 32'd1);

    // enable low for one cycle after 3 bits: word holds only the 8 new bits
    acc0 = acc_cnt;
    push_pair(1, 0); push_pair(1, 0); push_pair(1, 0);
    push_gap();
    push_pair(1, 0); push_pair(0, 1); push_pair(0, 1); push_pair(1, 0);
    push_pair(1, 0); push_pair(1, 0); push_pair(0, 1); push_pair(0, 1);
    run_sched(1'b1);
    drain(4);
    chk("en_count", 32'(acc_cnt - acc0), 32'd1);
    chk("en_word", 32'(last_acc), 32'h9C);

    // random traffic: random enable, raw_bit and ready
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset while a word is held and another is partly built
    for (int i = 0; i < 8; i++) push_pair(0, 1);
    push_pair(1, 0); push_pair(1, 0); push_pair(0, 1);
    run_sched(1'b0);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    async_reset();
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      push_pair(1, 0);
      push_pair(1, 1);
      push_pair(0, 1);
    end
    run_sched(1'b1);
    drain(4);
    chk("post_rst_count", 32'(acc_cnt - acc0), 32'd1);
    chk("post_rst_word", 32'(last_acc), 32'hAA);

    // constant raw_bit=1
    repeat (40) step(1'b1, 1'b1, 1'b1);
`ifdef TRNG_HEALTH_EN
    chk("hf_set", 32'(health_fail), 32'd1);
    chk("hf_valid_low", 32'(valid), 32'd0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'(i % 2), 1'b1);
    chk("hf_sticky", 32'(health_fail), 32'd1);
    chk("hf_sticky_valid", 32'(valid), 32'd0);
    async_reset();
    drain(2);
    chk("hf_cleared", 32'(health_fail), 32'd0);
`else
    chk("hf_absent", 32'(health_fail), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
